// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the two-requester SRAM arbiter.
// Combinational definitions only; no latency.
// No flow control here.
package sram_arb_pkg;
    localparam int ADDR_W_DEF = 20;
    localparam int DATA_W_DEF = 16;
    localparam int BE_W_DEF   = 2;
    localparam int MAX_OUT_DEF = 4;

    typedef logic rq_id_t;

    localparam rq_id_t RQ0 = 1'b0;
    localparam rq_id_t RQ1 = 1'b1;
endpackage

// File: rtl/sram_arb_id_fifo.sv
// Requester-ID FIFO recording the issue order of reads in flight.
// Head reflects the oldest entry combinationally; push/pop take effect at the edge.
// Caller must not push when full without a pop, nor pop when empty.
module sram_arb_id_fifo
    import sram_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic   clock_50mhz,
    input  logic   reset,
    input  logic   push,
    input  rq_id_t push_id,
    input  logic   pop,
    output logic   full,
    output logic   empty,
    output rq_id_t head
);
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;

    rq_id_t          mem [MAX_OUTSTANDING];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    // Depth is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clock_50mhz) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clock_50mhz) begin
        if (push) mem[wr_ptr] <= push_id;
    end

    assign full  = (count == CW'(MAX_OUTSTANDING));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];
endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one Avalon SRAM port between two requesters, routing reads back by issue order.
// Grant: 1 cycle from req to ack/strobe; return: 1 cycle from readdatavalid to rvalid.
// Requesters hold req until ack; reads stall while the ID FIFO is full unless a return frees a slot that cycle.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W          = ADDR_W_DEF,
    parameter int DATA_W          = DATA_W_DEF,
    parameter int BE_W            = BE_W_DEF,
    parameter int MAX_OUTSTANDING = MAX_OUT_DEF
) (
    input  logic              clock_50mhz,
    input  logic              reset,

    input  logic              rq0_req,
    input  logic              rq0_write,
    input  logic [ADDR_W-1:0] rq0_addr,
    input  logic [BE_W-1:0]   rq0_be,
    input  logic [DATA_W-1:0] rq0_wdata,
    output logic              rq0_ack,
    output logic [DATA_W-1:0] rq0_rdata,
    output logic              rq0_rvalid,

    input  logic              rq1_req,
    input  logic              rq1_write,
    input  logic [ADDR_W-1:0] rq1_addr,
    input  logic [BE_W-1:0]   rq1_be,
    input  logic [DATA_W-1:0] rq1_wdata,
    output logic              rq1_ack,
    output logic [DATA_W-1:0] rq1_rdata,
    output logic              rq1_rvalid,

    output logic [ADDR_W-1:0] sram_address,
    output logic [BE_W-1:0]   sram_byteenable,
    output logic              sram_read,
    output logic              sram_write,
    output logic [DATA_W-1:0] sram_writedata,
    input  logic [DATA_W-1:0] sram_readdata,
    input  logic              sram_readdatavalid,

    output logic              err_unexpected_rvalid
);
    rq_id_t last;
    logic   fifo_full;
    logic   fifo_empty;
    rq_id_t fifo_head;
    logic   fifo_pop;
    logic   fifo_push;
    logic   rd_ok;
    logic   elig0;
    logic   elig1;
    logic   gnt_vld;
    rq_id_t gnt_id;
    logic   gnt_write;

    // A return arriving this cycle frees a slot in time for a read granted on the same edge.
    always_comb begin
        fifo_pop  = sram_readdatavalid && !fifo_empty;
        rd_ok     = !fifo_full || fifo_pop;
        elig0     = rq0_req && !rq0_ack && (rq0_write || rd_ok);
        elig1     = rq1_req && !rq1_ack && (rq1_write || rd_ok);
        gnt_vld   = elig0 || elig1;
        gnt_id    = (elig0 && elig1) ? ~last : (elig1 ? RQ1 : RQ0);
        gnt_write = (gnt_id == RQ1) ? rq1_write : rq0_write;
        fifo_push = gnt_vld && !gnt_write;
    end

    sram_arb_id_fifo #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clock_50mhz (clock_50mhz),
        .reset       (reset),
        .push        (fifo_push),
        .push_id     (gnt_id),
        .pop         (fifo_pop),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .head        (fifo_head)
    );

    always_ff @(posedge clock_50mhz) begin
        if (reset) begin
            last                  <= RQ1;
            rq0_ack               <= 1'b0;
            rq1_ack               <= 1'b0;
            sram_read             <= 1'b0;
            sram_write            <= 1'b0;
            sram_address          <= '0;
            sram_byteenable       <= '0;
            sram_writedata        <= '0;
            rq0_rvalid            <= 1'b0;
            rq1_rvalid            <= 1'b0;
            rq0_rdata             <= '0;
            rq1_rdata             <= '0;
            err_unexpected_rvalid <= 1'b0;
        end else begin
            rq0_ack    <= gnt_vld && (gnt_id == RQ0);
            rq1_ack    <= gnt_vld && (gnt_id == RQ1);
            sram_read  <= fifo_push;
            sram_write <= gnt_vld && gnt_write;
            if (gnt_vld) begin
                last            <= gnt_id;
                sram_address    <= (gnt_id == RQ1) ? rq1_addr  : rq0_addr;
                sram_byteenable <= (gnt_id == RQ1) ? rq1_be    : rq0_be;
                sram_writedata  <= (gnt_id == RQ1) ? rq1_wdata : rq0_wdata;
            end

            rq0_rvalid <= fifo_pop && (fifo_head == RQ0);
            rq1_rvalid <= fifo_pop && (fifo_head == RQ1);
            if (fifo_pop && (fifo_head == RQ0)) rq0_rdata <= sram_readdata;
            if (fifo_pop && (fifo_head == RQ1)) rq1_rdata <= sram_readdata;

            if (sram_readdatavalid && fifo_empty) err_unexpected_rvalid <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed and random stimulus for sram_arbiter against a queue-based reference model.
module tb_sram_arbiter;
    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;
    localparam int BE_W   = 2;
    localparam int MAXO   = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              rq0_req, rq0_write, rq1_req, rq1_write;
    logic [ADDR_W-1:0] rq0_addr, rq1_addr;
    logic [BE_W-1:0]   rq0_be, rq1_be;
    logic [DATA_W-1:0] rq0_wdata, rq1_wdata;
    logic              rq0_ack, rq1_ack, rq0_rvalid, rq1_rvalid;
    logic [DATA_W-1:0] rq0_rdata, rq1_rdata;
    logic [ADDR_W-1:0] sram_address;
    logic [BE_W-1:0]   sram_byteenable;
    logic              sram_read, sram_write;
    logic [DATA_W-1:0] sram_writedata, sram_readdata;
    logic              sram_readdatavalid;
    logic              err_unexpected_rvalid;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    int                q_ids[$];
    int                m_last;
    logic              e_ack0, e_ack1, e_rv0, e_rv1, e_read, e_write, e_err;
    logic [DATA_W-1:0] e_rd0, e_rd1, e_wdata;
    logic [ADDR_W-1:0] e_addr;
    logic [BE_W-1:0]   e_be;

    always #10 clk = ~clk;

    sram_arbiter dut (
        .clock_50mhz           (clk),
        .reset                 (reset),
        .rq0_req               (rq0_req),
        .rq0_write             (rq0_write),
        .rq0_addr              (rq0_addr),
        .rq0_be                (rq0_be),
        .rq0_wdata             (rq0_wdata),
        .rq0_ack               (rq0_ack),
        .rq0_rdata             (rq0_rdata),
        .rq0_rvalid            (rq0_rvalid),
        .rq1_req               (rq1_req),
        .rq1_write             (rq1_write),
        .rq1_addr              (rq1_addr),
        .rq1_be                (rq1_be),
        .rq1_wdata             (rq1_wdata),
        .rq1_ack               (rq1_ack),
        .rq1_rdata             (rq1_rdata),
        .rq1_rvalid            (rq1_rvalid),
        .sram_address          (sram_address),
        .sram_byteenable       (sram_byteenable),
        .sram_read             (sram_read),
        .sram_write            (sram_write),
        .sram_writedata        (sram_writedata),
        .sram_readdata         (sram_readdata),
        .sram_readdatavalid    (sram_readdatavalid),
        .err_unexpected_rvalid (err_unexpected_rvalid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, predicting every output from the arbitration rules first.
    task automatic step();
        bit full, pop, e0, e1, gv, gw;
        int gid, id;
        if (reset) begin
            q_ids.delete();
            m_last = 1;
            {e_ack0, e_ack1, e_rv0, e_rv1, e_read, e_write, e_err} = '0;
            e_rd0 = '0; e_rd1 = '0; e_wdata = '0; e_addr = '0; e_be = '0;
        end else begin
            pop  = sram_readdatavalid && (q_ids.size() > 0);
            full = (q_ids.size() >= MAXO);
            e0 = rq0_req && !e_ack0 && (rq0_write || !full || pop);
            e1 = rq1_req && !e_ack1 && (rq1_write || !full || pop);
            gv = e0 || e1;
            if (e0 && e1) gid = 1 - m_last;
            else          gid = e1 ? 1 : 0;
            gw = (gid == 1) ? rq1_write : rq0_write;
            e_ack0  = gv && (gid == 0);
            e_ack1  = gv && (gid == 1);
            e_read  = gv && !gw;
            e_write = gv && gw;
            if (gv) begin
                m_last  = gid;
                e_addr  = (gid == 1) ? rq1_addr  : rq0_addr;
                e_be    = (gid == 1) ? rq1_be    : rq0_be;
                e_wdata = (gid == 1) ? rq1_wdata : rq0_wdata;
            end
            e_rv0 = 1'b0;
            e_rv1 = 1'b0;
            if (pop) begin
                id = q_ids.pop_front();
                if (id == 0) begin e_rv0 = 1'b1; e_rd0 = sram_readdata; end
                else         begin e_rv1 = 1'b1; e_rd1 = sram_readdata; end
            end else if (sram_readdatavalid) begin
                e_err = 1'b1;
            end
            if (gv && !gw) q_ids.push_back(gid);
        end
        @(posedge clk);
        #1;
        chk("rq0_ack", 32'(rq0_ack), 32'(e_ack0));
        chk("rq1_ack", 32'(rq1_ack), 32'(e_ack1));
        chk("sram_read", 32'(sram_read), 32'(e_read));
        chk("sram_write", 32'(sram_write), 32'(e_write));
        chk("sram_address", 32'(sram_address), 32'(e_addr));
        chk("sram_byteenable", 32'(sram_byteenable), 32'(e_be));
        chk("sram_writedata", 32'(sram_writedata), 32'(e_wdata));
        chk("rq0_rvalid", 32'(rq0_rvalid), 32'(e_rv0));
        chk("rq1_rvalid", 32'(rq1_rvalid), 32'(e_rv1));
        chk("rq0_rdata", 32'(rq0_rdata), 32'(e_rd0));
        chk("rq1_rdata", 32'(rq1_rdata), 32'(e_rd1));
        chk("err_unexpected_rvalid", 32'(err_unexpected_rvalid), 32'(e_err));
    endtask

    task automatic idle_inputs();
        rq0_req = 0; rq0_write = 0; rq0_addr = '0; rq0_be = '0; rq0_wdata = '0;
        rq1_req = 0; rq1_write = 0; rq1_addr = '0; rq1_be = '0; rq1_wdata = '0;
        sram_readdata = '0; sram_readdatavalid = 0;
    endtask

    task automatic do_reset();
        reset = 1; step();
        reset = 0;
    endtask

    initial begin
        idle_inputs();
        reset = 1;

        // Reset with random inputs: everything zero
        for (int i = 0; i < 2; i++) begin
            rq0_req = 1'($urandom); rq0_write = 1'($urandom); rq0_addr = ADDR_W'($urandom);
            rq1_req = 1'($urandom); rq1_write = 1'($urandom); rq1_wdata = DATA_W'($urandom);
            sram_readdatavalid = 1'($urandom); sram_readdata = DATA_W'($urandom);
            step();
        end
        chk("reset_err", 32'(err_unexpected_rvalid), 32'd0);
        chk("reset_addr", 32'(sram_address), 32'd0);
        reset = 0;
        idle_inputs();
        step();

        // Single read by rq0
        rq0_req = 1; rq0_write = 0; rq0_addr = 20'd3; rq0_be = 2'b11;
        step();
        chk("single_ack", 32'(rq0_ack), 32'd1);
        chk("single_read", 32'(sram_read), 32'd1);
        chk("single_addr", 32'(sram_address), 32'd3);
        rq0_req = 0;
        step();
        sram_readdatavalid = 1; sram_readdata = 16'hBEEF;
        step();
        sram_readdatavalid = 0;
        chk("single_rvalid0", 32'(rq0_rvalid), 32'd1);
        chk("single_rdata0", 32'(rq0_rdata), 32'hBEEF);
        chk("single_rvalid1", 32'(rq1_rvalid), 32'd0);

        // Contention: two held write requests alternate 0,1,0,1
        do_reset();
        rq0_req = 1; rq0_write = 1; rq0_addr = 20'h100; rq0_wdata = 16'hA0A0; rq0_be = 2'b01;
        rq1_req = 1; rq1_write = 1; rq1_addr = 20'h200; rq1_wdata = 16'h0B0B; rq1_be = 2'b10;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("cont_ack0", 32'(rq0_ack), 32'((i % 2) == 0));
            chk("cont_ack1", 32'(rq1_ack), 32'((i % 2) == 1));
            chk("cont_wdata", 32'(sram_writedata), (i % 2) == 0 ? 32'hA0A0 : 32'h0B0B);
        end
        idle_inputs();
        step();

        // Full FIFO: four rq1 reads, then read 5 stalls behind an rq0 write
        do_reset();
        for (int i = 0; i < 4; i++) begin
            rq1_req = 1; rq1_write = 0; rq1_addr = ADDR_W'(16 + i); rq1_be = 2'b11;
            step();
            chk("full_fill_ack", 32'(rq1_ack), 32'd1);
            rq1_req = 0;
            step();
        end
        rq1_req = 1; rq1_write = 0; rq1_addr = 20'd5;
        rq0_req = 1; rq0_write = 1; rq0_addr = 20'd7; rq0_wdata = 16'h1234;
        step();
        chk("full_wr_ack0", 32'(rq0_ack), 32'd1);
        chk("full_rd_stall", 32'(rq1_ack), 32'd0);
        rq0_req = 0;
        step();
        chk("full_rd_stall2", 32'(rq1_ack), 32'd0);
        sram_readdatavalid = 1; sram_readdata = 16'hAAAA;
        step();
        chk("full_pop_grant", 32'(rq1_ack), 32'd1);
        chk("full_pop_addr", 32'(sram_address), 32'd5);
        chk("full_pop_rvalid", 32'(rq1_rvalid), 32'd1);
        rq1_req = 0;
        for (int i = 0; i < 4; i++) begin
            sram_readdata = DATA_W'(16'h5000 + i);
            step();
            chk("full_drain_rvalid", 32'(rq1_rvalid), 32'd1);
        end
        step();
        chk("full_fifth_err", 32'(err_unexpected_rvalid), 32'd1);
        sram_readdatavalid = 0;
        step();

        // Interleaved returns route by issue order
        do_reset();
        rq0_req = 1; rq0_write = 0; rq0_addr = 20'hA;
        rq1_req = 1; rq1_write = 0; rq1_addr = 20'hB;
        step();
        chk("inter_first", 32'(rq0_ack), 32'd1);
        rq0_req = 0;
        step();
        chk("inter_second", 32'(rq1_ack), 32'd1);
        rq1_req = 0;
        sram_readdatavalid = 1; sram_readdata = 16'h1111;
        step();
        chk("inter_rdata0", 32'(rq0_rdata), 32'h1111);
        sram_readdata = 16'h2222;
        step();
        chk("inter_rdata1", 32'(rq1_rdata), 32'h2222);
        chk("inter_hold0", 32'(rq0_rdata), 32'h1111);
        sram_readdatavalid = 0;
        step();

        // Unexpected return, then reset with two reads in flight
        do_reset();
        sram_readdatavalid = 1; sram_readdata = 16'hDEAD;
        step();
        chk("unexp_rv0", 32'(rq0_rvalid), 32'd0);
        chk("unexp_rv1", 32'(rq1_rvalid), 32'd0);
        chk("unexp_err", 32'(err_unexpected_rvalid), 32'd1);
        sram_readdatavalid = 0;
        step();
        chk("unexp_sticky", 32'(err_unexpected_rvalid), 32'd1);
        do_reset();
        rq0_req = 1; rq0_write = 0; rq0_addr = 20'h21;
        step();
        rq0_req = 0; rq1_req = 1; rq1_write = 0; rq1_addr = 20'h22;
        step();
        rq1_req = 0;
        step();
        do_reset();
        sram_readdatavalid = 1;
        for (int i = 0; i < 2; i++) begin
            sram_readdata = DATA_W'(16'h7700 + i);
            step();
            chk("stale_rv0", 32'(rq0_rvalid), 32'd0);
            chk("stale_rv1", 32'(rq1_rvalid), 32'd0);
        end
        chk("stale_err", 32'(err_unexpected_rvalid), 32'd1);
        sram_readdatavalid = 0;

        // Random traffic obeying the hold-until-ack protocol
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (rq0_ack || !rq0_req) begin
                rq0_req   = ($urandom_range(0, 9) < 6);
                rq0_write = 1'($urandom);
                rq0_addr  = ADDR_W'($urandom);
                rq0_be    = BE_W'($urandom);
                rq0_wdata = DATA_W'($urandom);
            end
            if (rq1_ack || !rq1_req) begin
                rq1_req   = ($urandom_range(0, 9) < 6);
                rq1_write = 1'($urandom);
                rq1_addr  = ADDR_W'($urandom);
                rq1_be    = BE_W'($urandom);
                rq1_wdata = DATA_W'($urandom);
            end
            sram_readdatavalid = ($urandom_range(0, 2) == 0);
            sram_readdata      = DATA_W'($urandom);
            reset              = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
